// File: rtl/mem_bus_arbiter.sv
// Two-master, single-slave memory bus arbiter: LSU (m0) has fixed priority,
// fetch (m1) is protected by a starvation guard; one transaction in flight.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_be_i,
  output logic        m0_gnt_o,
  output logic        m0_rvalid_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_req_i,
  input  logic [31:0] m1_addr_i,
  output logic        m1_gnt_o,
  output logic        m1_rvalid_o,
  output logic [31:0] m1_rdata_o,
  output logic        hold_if_o,
  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_be_o,
  input  logic        s_gnt_i,
  input  logic        s_rvalid_i,
  input  logic [31:0] s_rdata_i
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_e;

  state_e           state_q, state_d;
  logic             owner_q, owner_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             init_q;
  logic             blocked;
  logic             any_req;
  logic             winner;
  logic             accept;

  // Outputs stay quiet during reset and for the first cycle after it.
  assign blocked = ~rst | init_q;
  assign any_req = m0_req_i | m1_req_i;
  // 1 selects m1: forced by the starvation guard, or m0 is not requesting.
  assign winner  = (m1_req_i & (starve_q == CNT_W'(STARVE_MAX))) | ~m0_req_i;
  assign accept  = (state_q == S_IDLE) & any_req & s_gnt_i & ~blocked;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      starve_q <= '0;
      init_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      init_q   <= 1'b0;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_WAIT;
          owner_d = winner;
          if (!winner && m1_req_i) begin
            starve_d = (starve_q < CNT_W'(STARVE_MAX)) ? starve_q + CNT_W'(1) : starve_q;
          end else begin
            starve_d = '0;
          end
        end
      end
      S_WAIT: begin
        if (s_rvalid_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    m0_gnt_o    = 1'b0;
    m0_rvalid_o = 1'b0;
    m0_rdata_o  = '0;
    m1_gnt_o    = 1'b0;
    m1_rvalid_o = 1'b0;
    m1_rdata_o  = '0;
    s_req_o     = 1'b0;
    s_we_o      = 1'b0;
    s_addr_o    = '0;
    s_wdata_o   = '0;
    s_be_o      = '0;
    hold_if_o   = m1_req_i;
    if (!blocked) begin
      if (state_q == S_IDLE) begin
        if (any_req) begin
          s_req_o   = 1'b1;
          s_we_o    = winner ? 1'b0 : m0_we_i;
          s_addr_o  = winner ? m1_addr_i : m0_addr_i;
          s_wdata_o = winner ? 32'h0 : m0_wdata_i;
          s_be_o    = winner ? 4'b1111 : m0_be_i;
          m0_gnt_o  = s_gnt_i & ~winner;
          m1_gnt_o  = s_gnt_i & winner;
          hold_if_o = m1_req_i & ~(s_gnt_i & winner);
        end
      end else if (s_rvalid_i) begin
        m0_rvalid_o = ~owner_q;
        m1_rvalid_o = owner_q;
        m0_rdata_o  = owner_q ? 32'h0 : s_rdata_i;
        m1_rdata_o  = owner_q ? s_rdata_i : 32'h0;
      end
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master, one-slave memory bus arbiter for the RV32 core. It shares a single-port instruction/data memory between the load/store unit (master 0) and the instruction fetch unit (master 1). Master 0 has fixed priority, with a starvation guard for fetch. It allows one outstanding transaction at a time and raises a fetch-hold signal so the pipeline stalls while fetch is locked out. It sits between `top`'s fetch/LSU paths and the memory model.

## Interface
- STARVE_MAX, 4: consecutive m0 grants allowed while m1 waits before m1 is forced to win (range 1..15).
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset (0 = reset)
- m0_req_i  in  1  LSU request; held until m0_gnt_o
- m0_we_i  in  1  1 = write, 0 = read
- m0_addr_i  in  32  LSU byte address
- m0_wdata_i  in  32  write data
- m0_be_i  in  4  byte enables
- m0_gnt_o  out  1  LSU request accepted this cycle
- m0_rvalid_o  out  1  LSU response (read data or write ack)
- m0_rdata_o  out  32  LSU read data
- m1_req_i  in  1  fetch request; held until m1_gnt_o
- m1_addr_i  in  32  fetch address (read only)
- m1_gnt_o  out  1  fetch request accepted
- m1_rvalid_o  out  1  fetch response
- m1_rdata_o  out  32  fetched instruction
- hold_if_o  out  1  m1_req_i high and m1 not granted this cycle
- s_req_o, s_we_o  out  1 each  slave request, write flag
- s_addr_o, s_wdata_o  out  32 each  slave address, write data
- s_be_o  out  4  slave byte enables (4'b1111 for m1)
- s_gnt_i, s_rvalid_i  in  1 each  slave accept, slave response
- s_rdata_i  in  32  slave read data

## Operation
- FSM has two states:
  - IDLE: arbitrate.
  - WAIT: one transaction outstanding; owner register holds 0 or 1.
- IDLE winner selection:
  - Forced m1 when m1_req_i=1 and starve_cnt==STARVE_MAX.
  - Otherwise m0 if m0_req_i=1, else m1 if m1_req_i=1.
- s_* request outputs are combinational from the winner. With no requester: s_req_o=0 and all other s_* outputs are 0.
- Grant:
  - In IDLE, s_gnt_i=1 with s_req_o=1 makes the winner's gnt_o=1 in the same cycle.
  - Next state is WAIT, and owner := winner.
  - If s_gnt_i=0, stay in IDLE and re-arbitrate next cycle; the winner may change, since the request was not accepted.
- WAIT:
  - s_req_o=0 and all gnt_o=0.
  - On s_rvalid_i=1: owner's rvalid_o=1 and rdata_o=s_rdata_i (same cycle, combinational), next state IDLE.
  - Writes also complete with rvalid; rdata is don't-care, driven as s_rdata_i.
- starve_cnt (4 bits) updates only on an accepted grant:
  - m0 granted while m1_req_i=1: increment, saturating at STARVE_MAX.
  - m1 granted, or m0 granted with m1_req_i=0: clear to 0.
- hold_if_o = m1_req_i & ~m1_gnt_o, in any state.
- Ignored inputs:
  - s_rvalid_i in IDLE is dropped; no rvalid_o.
  - s_gnt_i in WAIT is ignored.
- Non-owner rvalid_o=0 always. rdata_o of a non-owner is 0.

## Timing
- Reset (rst=0 at a clk edge): state=IDLE, owner=0, starve_cnt=0.
- Output values while rst=0 and in the cycle after:
  - All gnt_o, rvalid_o, rdata_o and s_* outputs are 0.
  - hold_if_o = m1_req_i.
- Reset mid-WAIT abandons the transaction. A late s_rvalid_i after reset arrives in IDLE and is ignored.
- Minimum latency: request in cycle N (s_gnt_i=1) -> rvalid in cycle N+1 (slave responds next cycle).
- Back-to-back: a new grant is possible no earlier than the cycle after rvalid. Peak throughput is one transaction per 2 cycles.
- Simultaneous m0/m1 requests in IDLE: m0 wins unless starvation is forced. m1's gnt comes at the earliest 2 cycles after m0's gnt.
- Slave stall (s_gnt_i low for k cycles): the grant is delayed k cycles, and hold_if_o stays high while m1 waits.

## Test plan
- Single fetch: m1_req_i=1, addr=0x4, s_gnt_i=1, s_rvalid_i next cycle with 0x00100593 -> m1_gnt_o pulses in cycle N, m1_rvalid_o=1 and m1_rdata_o=0x00100593 in N+1, hold_if_o=0 in N.
- Collision: m0 read 0x100 and m1 fetch 0x8 in the same cycle -> m0 granted in N (hold_if_o=1), m0_rvalid in N+1, m1 granted in N+2, m1_rvalid in N+3.
- Starvation: m0_req_i held high continuously, m1_req_i high, STARVE_MAX=4 -> 4 m0 grants, then m1 granted in the next IDLE, after which starve_cnt=0.
- Write ack: m0 write 0x200, wdata 0xDEADBEEF, be 4'b0011 -> s_we_o=1, s_be_o=4'b0011, s_wdata_o=0xDEADBEEF; m0_rvalid_o pulses once.
- Slave stall plus spurious response: s_gnt_i low 3 cycles -> gnt in the 4th cycle. An s_rvalid_i pulse while IDLE produces no rvalid_o.
- Reset mid-WAIT: grant m1, drive rst=0 for 1 cycle, then s_rvalid_i=1 -> m1_rvalid_o stays 0; FSM is IDLE and accepts a new m0 request the next cycle.
